// File: rtl/snn_pkg.sv
// Shared definitions for the SNN input loader.
//   loader_state_t : loader FSM states
//   PIXELS         : pixels in one image (28 x 28)
//   ADDR_W         : input-RAM pixel address width
//   BYTE_W         : UART byte width
package snn_pkg;

  localparam int PIXELS = 784;
  localparam int ADDR_W = 10;
  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    UNPACK    = 3'd1,
    NEXT      = 3'd2,
    READY     = 3'd3,
    WAIT_CORE = 3'd4
  } loader_state_t;

endpackage

// File: rtl/snn_input_loader_if.sv
// Signal bundle between the UART receiver / SNN core side and the input loader.
//   rx_rdy, rx_data : received byte strobe and data (into loader)
//   core_done       : classification finished pulse (into loader)
//   ram_we, ram_addr, ram_wdata : one-pixel-per-cycle input-RAM write port
//   frame_rdy       : full image stored, core may start
//   busy, overflow, timeout_err : status
// Modports: slave = the loader, master = whatever drives it.
interface snn_input_loader_if;
  import snn_pkg::*;

  logic              rx_rdy;
  logic [BYTE_W-1:0] rx_data;
  logic              core_done;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_wdata;
  logic              frame_rdy;
  logic              busy;
  logic              overflow;
  logic              timeout_err;

  modport slave (
    input  rx_rdy, rx_data, core_done,
    output ram_we, ram_addr, ram_wdata, frame_rdy, busy, overflow, timeout_err
  );

  modport master (
    output rx_rdy, rx_data, core_done,
    input  ram_we, ram_addr, ram_wdata, frame_rdy, busy, overflow, timeout_err
  );

endinterface

// File: rtl/snn_byte_skid.sv
// One-entry holding buffer for a byte that arrives while the loader is
// still unpacking the previous one.
//   clk, rst   : clock, synchronous active-high reset
//   push_i     : store data_i
//   pop_i      : consume the stored byte (data_o)
//   data_i     : byte to store
//   full_o     : a byte is stored
//   data_o     : stored byte
//   overflow_o : push while full and not popping this cycle (byte lost)
// A simultaneous push and pop replaces the stored byte.
module snn_byte_skid
  import snn_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [BYTE_W-1:0] data_i,
  output logic              full_o,
  output logic [BYTE_W-1:0] data_o,
  output logic              overflow_o
);

  logic              full_q, full_d;
  logic [BYTE_W-1:0] data_q, data_d;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (push_i && (!full_q || pop_i)) begin
      full_d = 1'b1;
      data_d = data_i;
    end else if (pop_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign full_o     = full_q;
  assign data_o     = data_q;
  assign overflow_o = push_i & full_q & ~pop_i;

endmodule

// File: rtl/snn_input_loader.sv
// Unpacks UART bytes (8 pixels each, LSB first) into the SNN input RAM,
// one pixel per cycle, then hands the frame to the core.
//   clk, rst : clock, synchronous active-high reset
//   ldr      : snn_input_loader_if.slave (rx_rdy/rx_data/core_done in,
//              RAM write port, frame_rdy, busy, overflow, timeout_err out)
// Parameters: BYTES_PER_FRAME (bytes per image), TIMEOUT_CYCLES (inter-byte
// timeout in NEXT).
// Optional feature: define SNN_LOADER_TIMEOUT_EN to build the inter-byte
// timeout; otherwise timeout_err is tied low and NEXT waits forever.
module snn_input_loader
  import snn_pkg::*;
#(
  parameter int BYTES_PER_FRAME = 98,
  parameter int TIMEOUT_CYCLES  = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  snn_input_loader_if.slave ldr
);

  localparam int IDX_W = (BYTES_PER_FRAME > 1) ? $clog2(BYTES_PER_FRAME) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_FRAME - 1);

  loader_state_t     state_q, state_d;
  logic [IDX_W-1:0]  byte_idx_q, byte_idx_d;
  logic [2:0]        bit_q, bit_d;
  logic [BYTE_W-1:0] hold_q, hold_d;
  logic              overflow_q, overflow_d;
  logic [IDX_W-1:0]  idx_inc;

  logic              skid_push, skid_pop, skid_full, skid_ovf;
  logic [BYTE_W-1:0] skid_data;
  logic              drop;

`ifdef SNN_LOADER_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             timeout_q, timeout_d;
`endif

  snn_byte_skid u_skid (
    .clk        (clk),
    .rst        (rst),
    .push_i     (skid_push),
    .pop_i      (skid_pop),
    .data_i     (ldr.rx_data),
    .full_o     (skid_full),
    .data_o     (skid_data),
    .overflow_o (skid_ovf)
  );

  assign idx_inc = byte_idx_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    bit_d      = bit_q;
    hold_d     = hold_q;
    skid_push  = 1'b0;
    skid_pop   = 1'b0;
    drop       = 1'b0;
`ifdef SNN_LOADER_TIMEOUT_EN
    timer_d    = '0;
    timeout_d  = timeout_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (ldr.rx_rdy) begin
          hold_d  = ldr.rx_data;
          bit_d   = '0;
          state_d = UNPACK;
        end
      end
      NEXT: begin
        if (ldr.rx_rdy) begin
          hold_d  = ldr.rx_data;
          bit_d   = '0;
          state_d = UNPACK;
        end
`ifdef SNN_LOADER_TIMEOUT_EN
        else if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
          // Partial frame abandoned; an incoming byte on this very cycle
          // would have won above.
          byte_idx_d = '0;
          timeout_d  = 1'b1;
          state_d    = IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
`endif
      end
      UNPACK: begin
        bit_d = bit_q + 3'd1;
        if (bit_q != 3'd7) begin
          // A byte beyond the end of the frame has nowhere to go.
          if (ldr.rx_rdy) begin
            if (byte_idx_q == LAST_IDX) drop = 1'b1;
            else                        skid_push = 1'b1;
          end
        end else if (byte_idx_q == LAST_IDX) begin
          drop    = ldr.rx_rdy;
          state_d = READY;
        end else begin
          // Exit cycle: chain straight into the next byte when one is
          // waiting (skid first, then a byte arriving right now).
          byte_idx_d = idx_inc;
          if (skid_full) begin
            skid_pop = 1'b1;
            hold_d   = skid_data;
            if (ldr.rx_rdy) begin
              // The popped byte may already be the frame's last one.
              if (idx_inc == LAST_IDX) drop = 1'b1;
              else                     skid_push = 1'b1;
            end
          end else if (ldr.rx_rdy) begin
            hold_d = ldr.rx_data;
          end else begin
            state_d = NEXT;
          end
        end
      end
      READY: begin
        drop    = ldr.rx_rdy;
        state_d = WAIT_CORE;
      end
      WAIT_CORE: begin
        drop = ldr.rx_rdy;
        if (ldr.core_done) begin
          byte_idx_d = '0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    overflow_d = overflow_q | drop | skid_ovf;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      byte_idx_q <= '0;
      bit_q      <= '0;
      hold_q     <= '0;
      overflow_q <= 1'b0;
`ifdef SNN_LOADER_TIMEOUT_EN
      timer_q    <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      bit_q      <= bit_d;
      hold_q     <= hold_d;
      overflow_q <= overflow_d;
`ifdef SNN_LOADER_TIMEOUT_EN
      timer_q    <= timer_d;
      timeout_q  <= timeout_d;
`endif
    end
  end

  // Outputs are forced low while rst is high so that no RAM write can
  // land on the reset edge of an abandoned frame.
  assign ldr.ram_we    = ~rst & (state_q == UNPACK);
  assign ldr.ram_addr  = (~rst && state_q == UNPACK) ? ADDR_W'({byte_idx_q, bit_q}) : '0;
  assign ldr.ram_wdata = ~rst & (state_q == UNPACK) & hold_q[bit_q];
  assign ldr.frame_rdy = ~rst & (state_q == READY);
  assign ldr.busy      = ~rst & (state_q != IDLE);
  assign ldr.overflow  = ~rst & overflow_q;
`ifdef SNN_LOADER_TIMEOUT_EN
  assign ldr.timeout_err = ~rst & timeout_q;
`else
  assign ldr.timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_snn_input_loader.sv
module tb_snn_input_loader;
  import snn_pkg::*;

  localparam int BPF = 98;
  localparam int TO  = 500;

  logic clk = 1'b0;
  logic rst = 1'b1;

  snn_input_loader_if bus();

  snn_input_loader #(.BYTES_PER_FRAME(BPF), .TIMEOUT_CYCLES(TO)) dut (
    .clk (clk),
    .rst (rst),
    .ldr (bus)
  );

  always #5 clk = ~clk;

  // ---------------- counters (owned by the monitor) ----------------
  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // ---------------- reference model state ----------------
  typedef struct {
    int         start;
    logic [7:0] d;
    int         idx;
  } sched_t;
  sched_t sq[$];
  int m_cnt        = 0;
  int m_last_start = -100;
  bit m_ovf        = 0;
  bit m_to         = 0;

  // ---------------- observations (owned by the monitor) ----------------
  int   wr_cnt = 0;
  int   wr_addr_q[$];
  bit   wr_dat_q[$];
  int   wr_cyc_q[$];
  logic obs_ram [0:1023];
  int   last_wr_cyc = 0;
  int   last_wr_addr = -1;
  int   rdy_cnt = 0;
  int   rdy_gap = -1;
  int   rdy_after_addr = -1;

  // ---------------- literal check requests (owned by driver) ----------------
  string lit_nm  [0:63];
  int    lit_got [0:63];
  int    lit_exp [0:63];
  int    n_req = 0;
  int    n_done = 0;
  bit    all_done = 0;

  task automatic check(input string nm, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      if (fails <= 40)
        $display("FAIL %s cyc=%0d got=%0d expected=%0d", nm, cyc, got, exp);
    end
  endtask

  // ---------------- monitor / model / compare ----------------
  always @(negedge clk) begin
    int  e_we, e_addr, e_wd, e_rdy, e_busy, off;
    bit  acc;
    cyc++;

    e_we = 0; e_addr = 0; e_wd = 0;
    foreach (sq[k]) begin
      if (cyc >= sq[k].start && cyc < sq[k].start + 8) begin
        off    = cyc - sq[k].start;
        e_we   = 1;
        e_addr = 8 * sq[k].idx + off;
        e_wd   = int'(sq[k].d[off]);
      end
    end
    e_rdy  = (m_cnt == BPF && cyc == m_last_start + 8) ? 1 : 0;
    e_busy = (m_cnt > 0) ? 1 : 0;

    if (rst) begin
      check("ram_we",      int'(bus.ram_we),      0);
      check("ram_addr",    int'(bus.ram_addr),    0);
      check("ram_wdata",   int'(bus.ram_wdata),   0);
      check("frame_rdy",   int'(bus.frame_rdy),   0);
      check("busy",        int'(bus.busy),        0);
      check("overflow",    int'(bus.overflow),    0);
      check("timeout_err", int'(bus.timeout_err), 0);
    end else begin
      check("ram_we", int'(bus.ram_we), e_we);
      if (e_we == 1) begin
        check("ram_addr",  int'(bus.ram_addr),  e_addr);
        check("ram_wdata", int'(bus.ram_wdata), e_wd);
      end
      check("frame_rdy",   int'(bus.frame_rdy),   e_rdy);
      check("busy",        int'(bus.busy),        e_busy);
      check("overflow",    int'(bus.overflow),    int'(m_ovf));
      check("timeout_err", int'(bus.timeout_err), int'(m_to));
    end

    // raw observations for the directed literal checks
    if (!rst && bus.ram_we) begin
      wr_cnt++;
      wr_addr_q.push_back(int'(bus.ram_addr));
      wr_dat_q.push_back(bus.ram_wdata);
      wr_cyc_q.push_back(cyc);
      obs_ram[bus.ram_addr] = bus.ram_wdata;
      last_wr_cyc  = cyc;
      last_wr_addr = int'(bus.ram_addr);
    end
    if (!rst && bus.frame_rdy) begin
      rdy_cnt++;
      rdy_gap        = cyc - last_wr_cyc;
      rdy_after_addr = last_wr_addr;
    end

    // model update from this cycle's inputs
    if (rst) begin
      sq.delete();
      m_cnt = 0; m_last_start = -100; m_ovf = 0; m_to = 0;
    end else begin
      while (sq.size() > 0 && sq[0].start + 8 <= cyc + 1) void'(sq.pop_front());
      acc = 0;
      if (bus.rx_rdy) begin
        // A byte fits if the frame has room and at most one byte is
        // waiting behind the one being unpacked.
        if (m_cnt < BPF && m_last_start <= cyc + 1) begin
          sched_t s;
          s.start = (cyc + 1 > m_last_start + 8) ? cyc + 1 : m_last_start + 8;
          s.d     = bus.rx_data;
          s.idx   = m_cnt;
          sq.push_back(s);
          m_cnt++;
          m_last_start = s.start;
          acc = 1;
        end else begin
          m_ovf = 1;
        end
      end
      if (bus.core_done && m_cnt == BPF && cyc > m_last_start + 8) begin
        m_cnt = 0; m_last_start = -100;
      end
`ifdef SNN_LOADER_TIMEOUT_EN
      if (!acc && m_cnt > 0 && m_cnt < BPF && cyc == m_last_start + 7 + TO) begin
        m_cnt = 0; m_last_start = -100; m_to = 1;
        sq.delete();
      end
`endif
    end

    while (n_done < n_req) begin
      check(lit_nm[n_done], lit_got[n_done], lit_exp[n_done]);
      n_done++;
    end

    if (all_done || cyc > 90000) begin
      if (!all_done) begin
        tests++; fails++;
        $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input logic [7:0] b);
    bus.rx_rdy  = 1'b1;
    bus.rx_data = b;
    tick();
    bus.rx_rdy  = 1'b0;
  endtask

  task automatic pulse_core();
    bus.core_done = 1'b1;
    tick();
    bus.core_done = 1'b0;
  endtask

  task automatic do_rst();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic lit(input string nm, input int got, input int exp);
    if (n_req < 64) begin
      lit_nm[n_req]  = nm;
      lit_got[n_req] = got;
      lit_exp[n_req] = exp;
      n_req++;
    end
  endtask

  initial begin
    int         base, rbase, errs;
    logic [7:0] pat;
    logic [15:0] v;

    bus.rx_rdy    = 1'b0;
    bus.rx_data   = '0;
    bus.core_done = 1'b0;
    rst           = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(2);
    lit("reset_busy",     int'(bus.busy),     0);
    lit("reset_overflow", int'(bus.overflow), 0);

    // Full frame of 0xA5, one byte every 100 cycles
    base = wr_cnt; rbase = rdy_cnt;
    for (int i = 0; i < BPF; i++) begin
      send(8'hA5);
      idle(99);
    end
    lit("a5_writes",    wr_cnt - base, 784);
    lit("a5_frame_rdy", rdy_cnt - rbase, 1);
    lit("a5_rdy_gap",   rdy_gap, 1);
    lit("a5_rdy_after", rdy_after_addr, 783);
    pat  = 8'hA5;
    errs = 0;
    if (wr_cnt - base >= 784) begin
      for (int i = 0; i < 784; i++)
        if (wr_addr_q[base+i] != i || wr_dat_q[base+i] != pat[i%8]) errs++;
    end else errs = 9999;
    lit("a5_pattern_errs", errs, 0);
    lit("a5_busy_wait", int'(bus.busy), 1);
    pulse_core();
    idle(2);
    lit("a5_busy_after_done", int'(bus.busy), 0);

    // 0x01 then 0x80 one cycle apart: back-to-back unpack via skid
    do_rst();
    idle(2);
    base = wr_cnt;
    send(8'h01);
    idle(1);
    send(8'h80);
    idle(20);
    for (int i = 0; i < 16; i++) v[i] = obs_ram[i];
    lit("b2b_pixels", int'(v), 16'h8001);
    if (wr_cnt - base >= 9) lit("b2b_gap", wr_cyc_q[base+8] - wr_cyc_q[base+7], 1);
    else                    lit("b2b_gap", -1, 1);
    lit("b2b_overflow", int'(bus.overflow), 0);

    // Three bytes in three consecutive cycles: third is lost
    do_rst();
    idle(2);
    base = wr_cnt;
    send(8'h11); send(8'h22); send(8'h33);
    idle(30);
    lit("ovf3_flag",   int'(bus.overflow), 1);
    lit("ovf3_writes", wr_cnt - base, 16);
    idle(50);
    lit("ovf3_sticky", int'(bus.overflow), 1);
    do_rst();
    idle(1);
    lit("ovf3_cleared", int'(bus.overflow), 0);

    // 50 bytes, reset mid-frame, then a complete random frame
    for (int i = 0; i < 50; i++) begin
      send(8'($urandom));
      idle(9);
    end
    do_rst();
    idle(2);
    base = wr_cnt; rbase = rdy_cnt;
    for (int i = 0; i < BPF; i++) begin
      send(8'($urandom));
      idle($urandom_range(8, 12));
    end
    idle(20);
    lit("rst_first_addr", (wr_cnt > base) ? wr_addr_q[base] : -1, 0);
    lit("rst_frame_rdy",  rdy_cnt - rbase, 1);
    lit("rst_writes",     wr_cnt - base, 784);
    pulse_core();
    idle(2);

    // Frame with bytes landing on the unpack exit cycle, then a stray byte
    for (int i = 0; i < BPF; i++) begin
      send(8'($urandom));
      idle(7);
    end
    idle(15);
    base = wr_cnt;
    send(8'hFF);
    idle(5);
    lit("late_overflow", int'(bus.overflow), 1);
    lit("late_no_write", wr_cnt - base, 0);
    pulse_core();
    idle(2);
    lit("late_busy_done", int'(bus.busy), 0);
    base = wr_cnt;
    send(8'h3C);
    idle(12);
    lit("late_next_addr", (wr_cnt > base) ? wr_addr_q[base] : -1, 0);
    lit("late_next_cnt",  wr_cnt - base, 8);

    // Randomised traffic
    do_rst();
    for (int i = 0; i < 12000; i++) begin
      rst           = ($urandom_range(0, 2999) == 0);
      bus.core_done = ($urandom_range(0, 39) == 0);
      bus.rx_rdy    = (i < 6000) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 11) == 0);
      bus.rx_data   = 8'($urandom);
      tick();
    end
    rst = 1'b0; bus.core_done = 1'b0; bus.rx_rdy = 1'b0;
    idle(20);

`ifdef SNN_LOADER_TIMEOUT_EN
    do_rst();
    idle(2);
    rbase = rdy_cnt;
    for (int i = 0; i < 10; i++) begin
      send(8'($urandom));
      idle(9);
    end
    idle(600);
    lit("to_flag",      int'(bus.timeout_err), 1);
    lit("to_frame_rdy", rdy_cnt - rbase, 0);
    base = wr_cnt;
    send(8'h5A);
    idle(12);
    lit("to_next_addr", (wr_cnt > base) ? wr_addr_q[base] : -1, 0);
`else
    lit("to_tied_low", int'(bus.timeout_err), 0);
`endif

    idle(2);
    all_done = 1'b1;
    idle(5);
  end

endmodule

// File: doc/snn_input_loader.md
SNN_INPUT_LOADER -- requirements
Module: snn_input_loader

Interface
REQ-001 SHALL have parameter BYTES_PER_FRAME, default 98, giving the number of UART bytes per image (8 pixels per byte).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1_000_000, giving the inter-byte timeout in clk cycles (used only with SNN_LOADER_TIMEOUT_EN).
REQ-003 SHALL have one clock and a synchronous, active-high reset.
REQ-004 Port clk  input  1  system clock; all logic on the rising edge.
REQ-005 Port rst  input  1  synchronous active-high reset.
REQ-006 Port rx_rdy  input  1  one-cycle pulse from uart_rx: rx_data is valid.
REQ-007 Port rx_data  input  8  received byte.
REQ-008 Port ram_we  output  1  input-RAM write enable.
REQ-009 Port ram_addr  output  10  input-RAM pixel address.
REQ-010 Port ram_wdata  output  1  pixel bit.
REQ-011 Port frame_rdy  output  1  one-cycle pulse: the full image is in RAM and the core may start.
REQ-012 Port core_done  input  1  one-cycle pulse from the SNN core: classification finished.
REQ-013 Port busy  output  1  high from the first byte of a frame until core_done.
REQ-014 Port overflow  output  1  sticky: a byte was lost.
REQ-015 Port timeout_err  output  1  sticky: a partial frame was aborted.

Function
REQ-016 SHALL implement FSM states IDLE, UNPACK, NEXT, READY, WAIT_CORE.
REQ-017 IDLE/NEXT: on rx_rdy, capture rx_data into the holding register and go to UNPACK.
REQ-018 UNPACK SHALL take exactly 8 cycles: ram_we=1, ram_addr=8*byte_idx+j, ram_wdata=byte[j], j=0..7, LSB first.
REQ-019 After UNPACK: if byte_idx=BYTES_PER_FRAME-1, go to READY; otherwise increment byte_idx and go to NEXT.
REQ-020 READY SHALL assert frame_rdy for exactly one cycle, then go to WAIT_CORE.
REQ-021 The cycle after the last pixel write (address 783 by default) SHALL be the frame_rdy cycle.
REQ-022 WAIT_CORE: on core_done, clear byte_idx and go to IDLE; rx_rdy in WAIT_CORE SHALL set overflow and drop the byte.
REQ-023 A second rx_rdy arriving during UNPACK SHALL be stored in a one-entry skid register and processed immediately after the current UNPACK, with no idle cycle.
REQ-024 An rx_rdy arriving while the skid register is full SHALL set overflow and drop the byte.
REQ-025 rx_rdy and the UNPACK-exit cycle coinciding SHALL NOT lose the byte.
REQ-026 ram_addr SHALL never exceed 8*BYTES_PER_FRAME-1.
REQ-027 byte_idx SHALL NOT wrap.
REQ-028 ram_we SHALL be 0 outside UNPACK.
REQ-029 busy SHALL be 1 in UNPACK, NEXT, READY and WAIT_CORE, and 0 in IDLE.

Reset
REQ-030 On rst: state=IDLE; byte_idx, skid and timer cleared.
REQ-031 On rst: ram_we, ram_addr, ram_wdata, frame_rdy, busy, overflow and timeout_err are all 0.
REQ-032 rst mid-frame SHALL abandon the frame with no further RAM writes; the next byte starts at address 0.

Configuration
REQ-033 With SNN_LOADER_TIMEOUT_EN defined, a counter SHALL restart on every accepted byte while in NEXT.
REQ-034 With SNN_LOADER_TIMEOUT_EN defined, reaching TIMEOUT_CYCLES in NEXT SHALL set timeout_err, clear byte_idx and return to IDLE without frame_rdy.
REQ-035 With SNN_LOADER_TIMEOUT_EN undefined, no timeout counter SHALL be built, timeout_err SHALL be tied 0, and NEXT waits indefinitely.

Structure
REQ-036 Package snn_pkg SHALL hold the loader_state_t enum, PIXELS=784, ADDR_W=10 and BYTE_W=8.
REQ-037 Sub-module snn_byte_skid SHALL implement the one-entry skid buffer (push, pop, full, data, overflow); all other logic stays in snn_input_loader.

Verification
REQ-038 Send 98 bytes 8'hA5 spaced 100 cycles -> 784 writes with bit pattern 1,0,1,0,0,1,0,1 repeating; frame_rdy once, the cycle after addr 783 is written.
REQ-039 Send byte 8'h01 then byte 8'h80 one cycle apart -> addr 0=1, addr 1..14=0, addr 15=1, no gap between the two UNPACKs; overflow=0.
REQ-040 Send 3 bytes within 3 consecutive cycles -> third byte dropped, overflow=1 until rst.
REQ-041 Send 50 bytes, pulse rst, then send 98 bytes -> first write of the new frame at addr 0; exactly one frame_rdy.
REQ-042 Complete a frame, send a byte before core_done -> overflow=1 and no RAM write; core_done -> busy=0 and the next frame starts at addr 0.
REQ-043 With SNN_LOADER_TIMEOUT_EN and TIMEOUT_CYCLES=500, send 10 bytes then stall for 600 cycles -> timeout_err=1, no frame_rdy, and the next byte is written at addr 0.
